card_select_ctl: RTL

Game-state controller for the 4x4 memory-game board. It accepts card-click requests from the mouse/selection logic and sequences the reveal, compare, hold and hide phases. It maintains the face-up and matched masks consumed by the card renderer. It also configures the downstream rectangle-drawing stage with the position of the highlight rectangle, updating that configuration only at frame boundaries.

---
 rtl/memory_game_pkg.sv | 26 ++
 rtl/frame_sync_reg.sv | 38 +++
 rtl/card_select_ctl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/memory_game_pkg.sv
// Shared definitions for the memory-game block: board geometry, FSM
// encoding and the card-to-pixel position helper.
package memory_game_pkg;

  localparam int NUM_CARDS = 16;
  localparam int NUM_PAIRS = 8;
  localparam int GRID_COLS = 4;
  localparam int PAIR_ID_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ONE_UP = 3'd1,
    ST_CHECK  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Pixel offset of a row/column index; 11-bit wrap is intentional, the
  // geometry parameters are expected to keep every card below 2048.
  function automatic logic [10:0] card_pos(input logic [10:0] base,
                                           input logic [1:0]  k,
                                           input logic [10:0] pitch);
    return base + 11'(k) * pitch;
  endfunction

endpackage

// File: rtl/frame_sync_reg.sv
// Shadow register that only loads on a rising edge of vblnk, so downstream
// frame-rate consumers never see a mid-frame update. i_clr forces the bits
// selected by CLR_MASK to zero (clear wins over a simultaneous load).
module frame_sync_reg #(
  parameter int           W        = 23,
  parameter logic [W-1:0] CLR_MASK = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_vblnk,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic         r_vblnk_d;
  logic [W-1:0] r_q;
  logic         w_rise;
  logic [W-1:0] w_load;

  assign w_rise = i_vblnk & ~r_vblnk_d;
  assign w_load = w_rise ? i_d : r_q;

  // vblnk history plus shadow load on the blanking edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vblnk_d <= 1'b0;
      r_q       <= '0;
    end else begin
      r_vblnk_d <= i_vblnk;
      if (i_clr) r_q <= w_load & ~CLR_MASK;
      else       r_q <= w_load;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/card_select_ctl.sv
// Memory-game controller: accepts card clicks, sequences reveal / compare /
// hold / hide, tracks face-up and matched masks and drives a frame-synchronous
// highlight rectangle. Optional feature macro: MISS_COUNTER_EN adds the
// miss_count port with an 8-bit saturating mismatch counter.
module card_select_ctl
  import memory_game_pkg::*;
#(
  parameter int GRID_X      = 112,
  parameter int GRID_Y      = 84,
  parameter int CARD_W      = 180,
  parameter int CARD_H      = 140,
  parameter int GAP         = 20,
  parameter int HOLD_CYCLES = 65_000_000
) (
  input  logic                              pclk,
  input  logic                              rst_n,
  input  logic [NUM_CARDS*PAIR_ID_W-1:0]    board_values,
  input  logic                              restart,
  input  logic                              click_valid,
  input  logic [3:0]                        click_idx,
  output logic                              click_ack,
  output logic [NUM_CARDS-1:0]              revealed_mask,
  output logic [NUM_CARDS-1:0]              matched_mask,
  output logic [3:0]                        pairs_found,
  output logic                              game_done,
  input  logic                              vblnk,
  output logic [10:0]                       rect_x,
  output logic [10:0]                       rect_y,
  output logic                              rect_en
`ifdef MISS_COUNTER_EN
  ,output logic [7:0]                       miss_count
`endif
);

  // Counter holds HOLD_CYCLES-1 down to 0, i.e. HOLD_CYCLES cycles in HOLD
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t                 r_state, w_state_nxt;
  logic [NUM_CARDS-1:0]   r_revealed, r_matched;
  logic [3:0]             r_pairs;
  logic [3:0]             r_first, r_second;
  logic [HCW-1:0]         r_hold;
  logic                   r_ack;
  logic [10:0]            r_pend_x, r_pend_y;
  logic                   w_click_ok, w_pair_eq, w_pend_en;
  logic [22:0]            w_rect;
`ifdef MISS_COUNTER_EN
  logic [7:0]             r_miss;
`endif

  assign w_click_ok = click_valid &&
                      (r_state == ST_IDLE || r_state == ST_ONE_UP) &&
                      !r_revealed[click_idx] && !r_matched[click_idx];
  assign w_pair_eq  = board_values[{r_first, 2'b00} +: PAIR_ID_W] ==
                      board_values[{r_second, 2'b00} +: PAIR_ID_W];
  assign w_pend_en  = (r_state == ST_ONE_UP) || (r_state == ST_CHECK) ||
                      (r_state == ST_HOLD);

  // State register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: restart overrides everything, CHECK always resolves in one cycle
  always_comb begin
    w_state_nxt = r_state;
    if (restart) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_click_ok) w_state_nxt = ST_ONE_UP;
        ST_ONE_UP: if (w_click_ok) w_state_nxt = ST_CHECK;
        ST_CHECK:  if (!w_pair_eq) w_state_nxt = ST_HOLD;
                   else if (r_pairs == 4'(NUM_PAIRS - 1)) w_state_nxt = ST_DONE;
                   else w_state_nxt = ST_IDLE;
        ST_HOLD:   if (r_hold == '0) w_state_nxt = ST_IDLE;
        ST_DONE:   w_state_nxt = ST_DONE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Board masks, stored pair, hold timer and pending highlight
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_revealed <= '0;
      r_matched  <= '0;
      r_pairs    <= '0;
      r_first    <= '0;
      r_second   <= '0;
      r_hold     <= '0;
      r_ack      <= 1'b0;
      r_pend_x   <= '0;
      r_pend_y   <= '0;
`ifdef MISS_COUNTER_EN
      r_miss     <= '0;
`endif
    end else if (restart) begin
      r_revealed <= '0;
      r_matched  <= '0;
      r_pairs    <= '0;
      r_hold     <= '0;
      r_ack      <= 1'b0;
      r_pend_x   <= '0;
      r_pend_y   <= '0;
`ifdef MISS_COUNTER_EN
      r_miss     <= '0;
`endif
    end else begin
      r_ack <= w_click_ok;
      if (w_click_ok) begin
        r_revealed[click_idx] <= 1'b1;
        if (r_state == ST_IDLE) r_first  <= click_idx;
        else                    r_second <= click_idx;
        r_pend_x <= card_pos(11'(GRID_X), click_idx[1:0], 11'(CARD_W + GAP));
        r_pend_y <= card_pos(11'(GRID_Y), click_idx[3:2], 11'(CARD_H + GAP));
      end
      if (r_state == ST_CHECK) begin
        if (w_pair_eq) begin
          r_revealed[r_first]  <= 1'b0;
          r_revealed[r_second] <= 1'b0;
          r_matched[r_first]   <= 1'b1;
          r_matched[r_second]  <= 1'b1;
          r_pairs              <= r_pairs + 4'd1;
        end else begin
          r_hold <= HCW'(HOLD_CYCLES - 1);
`ifdef MISS_COUNTER_EN
          if (r_miss != 8'hFF) r_miss <= r_miss + 8'd1;
`endif
        end
      end
      if (r_state == ST_HOLD) begin
        if (r_hold == '0) begin
          r_revealed[r_first]  <= 1'b0;
          r_revealed[r_second] <= 1'b0;
        end else begin
          r_hold <= r_hold - 1'b1;
        end
      end
    end
  end

  frame_sync_reg #(.W(23), .CLR_MASK(23'h1)) u_fsync (
    .i_clk   (pclk),
    .i_rst_n (rst_n),
    .i_vblnk (vblnk),
    .i_clr   (restart),
    .i_d     ({r_pend_x, r_pend_y, w_pend_en}),
    .o_q     (w_rect)
  );

  assign click_ack     = r_ack;
  assign revealed_mask = r_revealed;
  assign matched_mask  = r_matched;
  assign pairs_found   = r_pairs;
  assign game_done     = (r_state == ST_DONE);
  assign rect_x        = w_rect[22:12];
  assign rect_y        = w_rect[11:1];
  assign rect_en       = w_rect[0];
`ifdef MISS_COUNTER_EN
  assign miss_count    = r_miss;
`endif

endmodule
